enc_cont_chk: RTL
=================

Name: enc_cont_chk

Overview:
- Multi-channel encoder continuity checker, parametrised in channel count, data width and counter widths.
- Sits beside the encoder sampling path; sees the same enc_vld-qualified samples the acquisition logic consumes.
- Per channel, flags any sample-to-sample change larger than a programmable step. Forward and optional backward motion are handled, with modulo-2^DW wrap.
- Per channel, reports the first sample, jump count, first-jump sample index and largest jump magnitude.

Parameters:
- CH_NUM, 2: number of encoder channels checked in parallel.
- DW, 18: encoder sample width per channel.
- CW, 48: sample index counter width.
- JW, 32: per-channel jump counter width.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  reset.
- cfg_rst  in  1  synchronous clear of all statistics; priority over enc_vld.
- cfg_max_step  in  DW  largest allowed modulo step between consecutive valid samples.
- cfg_bidir  in  1  1 = backward steps up to cfg_max_step are also legal.
- enc_vld  in  1  sample strobe, common to all channels.
- enc_din  in  CH_NUM*DW  samples; channel i at bits [i*DW +: DW].
- smp_cnt  out  CW  number of accepted samples, saturating.
- enc_1st  out  CH_NUM*DW  first sample after reset/cfg_rst, per channel.
- jp_num  out  CH_NUM*JW  jump count per channel, saturating.
- jp_pos_1st  out  CH_NUM*CW  sample index of the first jump per channel.
- jp_max  out  CH_NUM*DW  largest jump magnitude seen per channel.
- jp_flag  out  CH_NUM  sticky: channel has seen at least one jump.

Behaviour:
- Interface: reset sys_rst_n, asynchronous, active-low; clock sys_clk.
- Reset value of every output and internal register is 0. cfg_rst at a clock edge produces the same values and discards that cycle's sample.
- Sample index k is the value of smp_cnt at the edge where the sample is accepted. First sample k=0.
- smp_cnt increments on each enc_vld edge and saturates at 2^CW-1. Saturation does not stop checking.
- k=0: enc_1st[i] <= enc_din[i]; prev[i] <= enc_din[i]. No check is made.
- k>=1, per channel:
  - fwd = (cur - prev) mod 2^DW.
  - bwd = (prev - cur) mod 2^DW.
  - legal if fwd == 0, or fwd <= cfg_max_step, or (cfg_bidir && bwd <= cfg_max_step).
  - Otherwise a jump event occurs at index k.
- prev[i] <= cur on every accepted sample, legal or not. Checking restarts from the new value, so one glitch sample gives 2 jumps (into and out of it).
- Wrap: 2^DW-1 -> 0 gives fwd=1, legal for cfg_max_step>=1. 0 -> 2^DW-1 gives bwd=1, legal only if cfg_bidir.
- cfg_max_step = 0: only repeated values are legal.
- On a jump event, at the same edge:
  - jp_num[i] += 1, saturating at 2^JW-1.
  - jp_flag[i] <= 1.
  - If jp_flag[i] was 0: jp_pos_1st[i] <= k.
  - mag = min(fwd, bwd); if mag > jp_max[i], jp_max[i] <= mag.
- Latency: all outputs reflect sample k one clock after its enc_vld edge. The check is combinational against registered prev.
- Channels are fully independent. Several channels may jump at the same edge.
- cfg_max_step and cfg_bidir are read live at each check. Changes take effect on the next sample; past statistics are not re-evaluated.
- enc_vld low: all state holds.
- sys_rst_n asserted mid-stream: everything clears. The next valid sample is k=0 again and is never flagged.
- cfg_rst together with enc_vld: clear wins; the sample is not counted and not stored.

Test Plan (DW=18, CH_NUM=2, CW=48, JW=32, cfg_max_step=1, cfg_bidir=0 unless stated):
- Ch0 ramp 100..109, ch1 constant 5 -> smp_cnt=10, enc_1st={5,100}, jp_num=0 both, jp_flag=0, jp_max=0.
- Ch0 262142, 262143, 0, 1 -> no jump. Then cfg_bidir=0 with 1, 0 -> jp_num[0]=1, jp_pos_1st[0]=4, jp_max[0]=1. Repeat with cfg_bidir=1 -> no jump.
- Ch1 10, 11, 500, 12, 13 -> jp_num[1]=2, jp_pos_1st[1]=2, jp_max[1]=489, jp_flag=2'b10; ch0 unaffected.
- cfg_max_step=4, ch0 0, 4, 9 -> one jump at k=2 (step 5), jp_max[0]=5. With cfg_max_step=0, repeated 7,7,7 -> no jump; 7->8 -> jump.
- Jump at k=3, then cfg_rst pulsed in the same cycle as enc_vld -> all outputs 0 next cycle. Next sample gives enc_1st = that sample, smp_cnt=1.
- sys_rst_n low asynchronously mid-stream -> outputs 0 immediately. Following first sample is not checked, even if far from the pre-reset value.

Source files
------------

// File: rtl/enc_cont_chk.sv
// Per-channel encoder continuity checker: flags modulo steps larger than cfg_max_step and keeps jump statistics.
// Latency: every output reflects a sample one sys_clk after the enc_vld edge that accepts it.
// Backpressure: none; each enc_vld sample is consumed unconditionally, and cfg_rst discards that cycle's sample.
module enc_cont_chk #(
  parameter int CH_NUM = 2,
  parameter int DW     = 18,
  parameter int CW     = 48,
  parameter int JW     = 32
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 cfg_rst,
  input  logic [DW-1:0]        cfg_max_step,
  input  logic                 cfg_bidir,
  input  logic                 enc_vld,
  input  logic [CH_NUM*DW-1:0] enc_din,
  output logic [CW-1:0]        smp_cnt,
  output logic [CH_NUM*DW-1:0] enc_1st,
  output logic [CH_NUM*JW-1:0] jp_num,
  output logic [CH_NUM*CW-1:0] jp_pos_1st,
  output logic [CH_NUM*DW-1:0] jp_max,
  output logic [CH_NUM-1:0]    jp_flag
);

  logic smp_acc;
  logic first_smp;
  logic chk_en;

  // smp_cnt saturates at all-ones and never wraps back to zero, so zero uniquely marks "no sample yet"
  assign smp_acc   = enc_vld && !cfg_rst;
  assign first_smp = smp_acc && (smp_cnt == '0);
  assign chk_en    = smp_acc && (smp_cnt != '0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      smp_cnt <= '0;
    end else if (cfg_rst) begin
      smp_cnt <= '0;
    end else if (enc_vld && (smp_cnt != '1)) begin
      smp_cnt <= smp_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [DW-1:0] cur;
    logic [DW-1:0] prev_q;
    logic [DW-1:0] fwd;
    logic [DW-1:0] bwd;
    logic [DW-1:0] mag;
    logic [DW-1:0] first_q;
    logic [DW-1:0] max_q;
    logic [JW-1:0] num_q;
    logic [CW-1:0] pos_q;
    logic          flag_q;
    logic          legal;
    logic          jump;

    assign cur   = enc_din[i*DW +: DW];
    // Subtraction in DW bits gives the modulo-2^DW distance in each direction
    assign fwd   = cur - prev_q;
    assign bwd   = prev_q - cur;
    assign mag   = (fwd < bwd) ? fwd : bwd;
    assign legal = (fwd == '0) || (fwd <= cfg_max_step) ||
                   (cfg_bidir && (bwd <= cfg_max_step));
    assign jump  = chk_en && !legal;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        prev_q  <= '0;
        first_q <= '0;
        max_q   <= '0;
        num_q   <= '0;
        pos_q   <= '0;
        flag_q  <= 1'b0;
      end else if (cfg_rst) begin
        prev_q  <= '0;
        first_q <= '0;
        max_q   <= '0;
        num_q   <= '0;
        pos_q   <= '0;
        flag_q  <= 1'b0;
      end else if (enc_vld) begin
        // A glitch sample still becomes the reference, so leaving it counts as a second jump
        prev_q <= cur;
        if (first_smp) begin
          first_q <= cur;
        end
        if (jump) begin
          flag_q <= 1'b1;
          if (num_q != '1) begin
            num_q <= num_q + 1'b1;
          end
          if (!flag_q) begin
            pos_q <= smp_cnt;
          end
          if (mag > max_q) begin
            max_q <= mag;
          end
        end
      end
    end

    assign enc_1st[i*DW +: DW]    = first_q;
    assign jp_num[i*JW +: JW]     = num_q;
    assign jp_pos_1st[i*CW +: CW] = pos_q;
    assign jp_max[i*DW +: DW]     = max_q;
    assign jp_flag[i]             = flag_q;
  end

endmodule
